// File: rtl/sdr_16_rd_capture_pkg.sv
`default_nettype none
// =============================================================================
// sdr_16_rd_capture_pkg : shared constants and types for the SDR read capture
// Revision 1.0
// =============================================================================
package sdr_16_rd_capture_pkg;

   localparam int INIT_CL       = 2;
   localparam int RD_INFLIGHT_W = 4;
   localparam int DQ_W          = 16;

   typedef enum logic [1:0] {
      CAP_IDLE = 2'b00,
      CAP_HI   = 2'b01,
      CAP_LO   = 2'b10
   } cap_state_e;

   typedef logic [RD_INFLIGHT_W-1:0] inflight_t;

   localparam inflight_t INFLIGHT_MAX = '1;

endpackage
`default_nettype wire

// File: rtl/sdr_16_rd_capture_if.sv
`default_nettype none
// =============================================================================
// sdr_16_rd_capture_if : controller / ingress-FIFO side bundle of the capture
// Revision 1.0
// =============================================================================
interface sdr_16_rd_capture_if;
   import sdr_16_rd_capture_pkg::*;

   logic              cmd_read;
   logic              dq_oe;
   logic [DQ_W-1:0]   dq_i;
   logic              fifo_full;
   logic              err_clr;
   logic              fifo_we;
   logic [2*DQ_W-1:0] fifo_wdata;
   logic              rd_busy;
   logic              err_ovf;
   logic              err_proto;

   modport master (
      output cmd_read, dq_oe, dq_i, fifo_full, err_clr,
      input  fifo_we, fifo_wdata, rd_busy, err_ovf, err_proto
   );

   modport slave (
      input  cmd_read, dq_oe, dq_i, fifo_full, err_clr,
      output fifo_we, fifo_wdata, rd_busy, err_ovf, err_proto
   );

endinterface
`default_nettype wire

// File: rtl/sdr_16_dly_line.sv
`default_nettype none
// =============================================================================
// sdr_16_dly_line : single-bit shift register, DEPTH stages, sync active-low clear
// Revision 1.0
// =============================================================================
module sdr_16_dly_line #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   generate
      if (DEPTH == 1) begin : g_single
         always_comb sr_d = din;
      end else begin : g_multi
         always_comb sr_d = {sr_q[DEPTH-2:0], din};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout = sr_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sdr_16_rd_capture.sv
`default_nettype none
// =============================================================================
// sdr_16_rd_capture : aligns read commands to CL+IO_LAT, packs two beats per push
// Revision 1.0
// =============================================================================
module sdr_16_rd_capture
   import sdr_16_rd_capture_pkg::*;
#(
   parameter int CL     = INIT_CL,
   parameter int IO_LAT = 1
) (
   input  logic               sdram_clk,
   input  logic               sdram_rst_n,
   sdr_16_rd_capture_if.slave bus
);

   localparam int DEPTH = CL + IO_LAT;

   cap_state_e        state_q, state_d;
   logic [DQ_W-1:0]   hi_q, hi_d;
   logic [2*DQ_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              cmd_prev_q, cmd_prev_d;
   logic              ovf_q, ovf_d;
   logic              proto_q, proto_d;
   inflight_t         cnt_q, cnt_d;

   logic rd_accept;
   logic rd_dup;
   logic tag_out;
   logic beat_sample;
   logic cnt_sat;

   // A second pulse in back-to-back cycles is flagged and never launched.
   assign rd_accept = bus.cmd_read & ~cmd_prev_q;
   assign rd_dup    = bus.cmd_read &  cmd_prev_q;

   sdr_16_dly_line #(
      .DEPTH (DEPTH)
   ) u_dly (
      .clk   (sdram_clk),
      .rst_n (sdram_rst_n),
      .din   (rd_accept),
      .dout  (tag_out)
   );

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      wdata_d     = wdata_q;
      we_d        = 1'b0;
      cmd_prev_d  = bus.cmd_read;
      cnt_d       = cnt_q;
      cnt_sat     = 1'b0;
      beat_sample = 1'b0;

      // The push is registered on the HI->LO edge so it lands in the LO cycle.
      case (state_q)
         CAP_HI: begin
            state_d     = CAP_LO;
            wdata_d     = {hi_q, bus.dq_i};
            we_d        = 1'b1;
            beat_sample = 1'b1;
         end
         default: begin
            if (tag_out) begin
               state_d     = CAP_HI;
               hi_d        = bus.dq_i;
               beat_sample = 1'b1;
            end else begin
               state_d = CAP_IDLE;
            end
         end
      endcase

      if (rd_accept && !we_q) begin
         if (cnt_q == INFLIGHT_MAX) begin
            cnt_sat = 1'b1;
         end else begin
            cnt_d = cnt_q + inflight_t'(1);
         end
      end else if (we_q && !rd_accept && (cnt_q != '0)) begin
         cnt_d = cnt_q - inflight_t'(1);
      end

      proto_d = rd_dup | (bus.dq_oe & beat_sample) | cnt_sat | (proto_q & ~bus.err_clr);
      ovf_d   = (we_q & bus.fifo_full) | (ovf_q & ~bus.err_clr);
   end

   always_ff @(posedge sdram_clk) begin
      if (!sdram_rst_n) begin
         state_q    <= CAP_IDLE;
         hi_q       <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         cmd_prev_q <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         proto_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         cmd_prev_q <= cmd_prev_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         proto_q    <= proto_d;
      end
   end

   assign bus.fifo_we    = we_q;
   assign bus.fifo_wdata = wdata_q;
   assign bus.rd_busy    = (cnt_q != '0);
   assign bus.err_ovf    = ovf_q;
   assign bus.err_proto  = proto_q;

endmodule
`default_nettype wire
